serial_adder_sub: RTL and testbench
===================================

// Module: serial_adder_sub
// PURPOSE
//  Multi-cycle, digit-serial adder/subtractor. Adds or subtracts two WIDTH-bit operands
//  DIGIT bits per clock, LSB first, over a start/done handshake.
//  Reuses one DIGIT-bit full-adder slice across cycles.
//  Forms the datapath arithmetic unit for area-constrained lab designs.
//  Extends the single-bit full adder with width, digit size, subtract mode, and overflow.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  1  bits processed per cycle (1 <= DIGIT <= WIDTH); STEPS = WIDTH/DIGIT
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  sub    in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored); latched with start
//  a      in   WIDTH  operand A; latched with start
//  b      in   WIDTH  operand B; latched with start
//  cin    in   1      carry-in for add mode; latched with start
//  busy   out  1      1 while digits are being processed
//  done   out  1      one-cycle pulse; sum/cout/ovf are valid from this cycle on
//  sum    out  WIDTH  result, registered
//  cout   out  1      carry out of MSB (sub mode: 1 = no borrow)
//  ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0;
//    digit counter=0. Dominates start.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN. RUN --last digit--> DONE. DONE --> IDLE, or DONE --start--> RUN.
//  - Accept edge E0 (start=1, state IDLE or DONE):
//    - latch a, b^{WIDTH{sub}}, and carry = sub ? 1 : cin;
//    - counter=0; busy=1 from the following cycle.
//  - RUN, edges E1..E_STEPS: edge Ek adds slice k-1 of the latched operands plus the
//    carry register using a DIGIT-bit add, writes the slice into the internal result,
//    and updates the carry register.
//  - Edge E_STEPS:
//    - state goes to DONE; busy=0; done=1 for exactly one cycle;
//    - sum, cout, and ovf load together;
//    - ovf uses the carry into bit WIDTH-1 from the final slice (DIGIT=1: that slice's carry-in).
//  - Latency: done is high STEPS cycles after the accept edge. Throughput: one op every
//    STEPS+1 cycles with back-to-back start.
//  - start while busy=1 is ignored; latched operands are unaffected by input changes
//    after E0.
//  - sum/cout/ovf hold their last result until the next completion, and are not
//    disturbed by a new accept.
//  - Wrap-around: the result is modulo 2^WIDTH; the carry out of MSB appears only on cout.
//  - rst during RUN aborts the operation: no done pulse; outputs return to reset values.
//  - DIGIT=WIDTH degenerates to a single-step add: done one cycle after accept.
// TESTING (WIDTH=8, DIGIT=1 unless stated)
//  1. Add 8'h0F+8'h01, cin=0.
//     -> done exactly 8 cycles after the accept edge; sum=8'h10, cout=0, ovf=0; busy=1 for 8 cycles.
//  2. Add 8'hFF+8'h01, cin=0.
//     -> sum=8'h00, cout=1, ovf=0. Then 8'h7F+8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
//  3. Subtract 8'h05-8'h07.
//     -> sum=8'hFE, cout=0, ovf=0. Then 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
//  4. Pulse start again mid-RUN with different a/b.
//     -> ignored; the first result is unchanged.
//     Then assert start in the DONE cycle -> accepted; second result after 8 more cycles.
//  5. Assert rst 3 cycles into RUN.
//     -> next cycle: busy=0, sum=0, cout=0, ovf=0; no done pulse ever appears for that operation.
//  6. Exhaustive check at WIDTH=4 with DIGIT=1, 2, 4: all a, b, cin, sub combinations
//     (1024 ops) vs the behavioural {cout,sum} model.
//     -> zero mismatches; done latency = 4, 2, 1 respectively.

Source files
------------

// File: rtl/serial_adder_sub_if.sv
// serial_adder_sub_if
//   Request/response bundle for the digit-serial adder/subtractor.
//   master : drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the arithmetic unit side (directions reversed)
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_sub.sv
// serial_adder_sub
//   Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first,
//   reusing one DIGIT-bit adder slice. Result after WIDTH/DIGIT RUN cycles.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : serial_adder_sub_if.slave
//            start/sub/a/b/cin in (latched on accept),
//            busy/done/sum/cout/ovf out (all registered)
module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_sub_if.slave   bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] slice_ext;
    logic             carry_msb;
    logic             last;

    always_comb begin
        // Operand registers shift right each step, so the active slice is
        // always in the low DIGIT bits.
        dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + (DIGIT+1)'(carry_q);
        // Carry into the slice's top bit recovered from its sum bit.
        carry_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        slice_ext = '0;
        slice_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
        last      = (cnt_q == CW'(STEPS - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // Result fills from the top; after STEPS shifts it is aligned.
                res_d   = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_d;
                    cout_d  = dsum[DIGIT];
                    ovf_d   = carry_msb ^ dsum[DIGIT];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub
//   Scoreboard bench: drivers push expected results computed with plain
//   integer arithmetic; per-instance monitors pop and compare on done.
//   Instances: WIDTH=8/DIGIT=1 (directed + random), WIDTH=4 with DIGIT=1,2,4
//   (exhaustive).
module tb_serial_adder_sub;
    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin8 = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: unsigned sum/difference for sum and carry, signed range check for ovf.
    function automatic exp_t model(int w, int a, int b, bit ci, bit sb, int t);
        exp_t e;
        int m   = 1 << w;
        int sa  = (a >= m / 2) ? a - m : a;
        int sbv = (b >= m / 2) ? b - m : b;
        int u;
        int r;
        if (sb) begin
            u      = a - b + m;
            e.cout = (a >= b);
            r      = sa - sbv;
        end else begin
            u      = a + b + int'(ci);
            e.cout = (u >= m);
            r      = sa + sbv + int'(ci);
        end
        e.sum = 8'(u % m);
        e.ovf = (r >= m / 2) || (r < -(m / 2));
        e.t   = t;
        return e;
    endfunction

    // ---------------- WIDTH=8, DIGIT=1 instance ----------------
    serial_adder_sub_if #(.WIDTH(8)) if8 ();
    serial_adder_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8.slave)
    );

    exp_t q8[$];
    int   bcnt8 = 0;

    initial forever begin
        @(negedge clk);
        if (rst8) begin
            bcnt8 = 0;
        end else begin
            if (if8.busy) bcnt8++;
            if (if8.done) begin
                chk("w8_done_expected", int'(q8.size() > 0), 1);
                if (q8.size() > 0) begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("w8_sum", int'(if8.sum), int'(e.sum));
                    chk("w8_cout", int'(if8.cout), int'(e.cout));
                    chk("w8_ovf", int'(if8.ovf), int'(e.ovf));
                    chk("w8_latency", cyc - e.t, 8);
                    chk("w8_busy_cycles", bcnt8, 8);
                end
                bcnt8 = 0;
            end
        end
    end

    task automatic wait_free8();
        for (int k = 0; k < 40 && if8.busy !== 1'b0; k++) @(negedge clk);
        chk("w8_free", int'(if8.busy), 0);
    endtask

    task automatic op8(input int a, input int b, input bit ci, input bit sb);
        wait_free8();
        if8.a     = 8'(a);
        if8.b     = 8'(b);
        if8.cin   = ci;
        if8.sub   = sb;
        if8.start = 1'b1;
        q8.push_back(model(8, a, b, ci, sb, cyc + 1));
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic drain8();
        for (int k = 0; k < 60 && q8.size() != 0; k++) @(negedge clk);
        chk("w8_drain", q8.size(), 0);
    endtask

    initial begin
        bit saw;
        if8.start = 1'b0;
        if8.sub   = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if8.cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(if8.busy), 0);
        chk("rst_done", int'(if8.done), 0);
        chk("rst_sum", int'(if8.sum), 0);
        chk("rst_cout", int'(if8.cout), 0);
        chk("rst_ovf", int'(if8.ovf), 0);
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        op8(8'h0F, 8'h01, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'h7F, 8'h00, 1'b1, 1'b0);
        op8(8'h05, 8'h07, 1'b0, 1'b1);
        op8(8'h80, 8'h01, 1'b1, 1'b1);
        drain8();

        // Start pulsed mid-run must be ignored.
        op8(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        if8.a     = 8'hAA;
        if8.b     = 8'h55;
        if8.sub   = 1'b1;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        drain8();

        // Back-to-back: second start lands in the DONE cycle.
        op8(8'h20, 8'h03, 1'b0, 1'b0);
        op8(8'h40, 8'h05, 1'b0, 1'b1);
        chk("w8_sum_kept_on_accept", int'(if8.sum), 8'h23);
        drain8();
        repeat (5) @(negedge clk);
        chk("w8_sum_hold_idle", int'(if8.sum), 8'h3B);
        chk("w8_cout_hold_idle", int'(if8.cout), 1);

        // Reset mid-run aborts without a done pulse.
        if8.a     = 8'h11;
        if8.b     = 8'h22;
        if8.sub   = 1'b0;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(if8.busy), 0);
        chk("abort_sum", int'(if8.sum), 0);
        chk("abort_cout", int'(if8.cout), 0);
        chk("abort_ovf", int'(if8.ovf), 0);
        rst8 = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (if8.done) saw = 1'b1;
        end
        chk("abort_no_done", int'(saw), 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain8();
        fin8 = 1'b1;
    end

    // ---------------- WIDTH=4 exhaustive instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g4
        localparam int D  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int ST = 4 / D;

        serial_adder_sub_if #(.WIDTH(4)) bus ();
        serial_adder_sub #(.WIDTH(4), .DIGIT(D)) u_dut (
            .clk (clk),
            .rst (rst4),
            .bus (bus.slave)
        );

        exp_t q[$];
        int   bcnt = 0;
        bit   fin = 1'b0;

        initial begin
            bus.start = 1'b0;
            bus.sub   = 1'b0;
            bus.a     = '0;
            bus.b     = '0;
            bus.cin   = 1'b0;
            for (int k = 0; k < 10 && rst4 !== 1'b0; k++) @(negedge clk);
            @(negedge clk);
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        for (int s = 0; s < 2; s++) begin
                            for (int k = 0; k < 20 && bus.busy !== 1'b0; k++) @(negedge clk);
                            if (bus.busy !== 1'b0)
                                chk($sformatf("w4d%0d_free", D), int'(bus.busy), 0);
                            bus.a     = 4'(a);
                            bus.b     = 4'(b);
                            bus.cin   = 1'(c);
                            bus.sub   = 1'(s);
                            bus.start = 1'b1;
                            q.push_back(model(4, a, b, 1'(c), 1'(s), cyc + 1));
                            @(negedge clk);
                            bus.start = 1'b0;
                        end
                    end
                end
            end
            for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
            fin = 1'b1;
        end

        initial forever begin
            @(negedge clk);
            if (rst4) begin
                bcnt = 0;
            end else begin
                if (bus.busy) bcnt++;
                if (bus.done) begin
                    chk($sformatf("w4d%0d_done_expected", D), int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("w4d%0d_sum", D), int'(bus.sum), int'(e.sum));
                        chk($sformatf("w4d%0d_cout", D), int'(bus.cout), int'(e.cout));
                        chk($sformatf("w4d%0d_ovf", D), int'(bus.ovf), int'(e.ovf));
                        chk($sformatf("w4d%0d_latency", D), cyc - e.t, ST);
                        chk($sformatf("w4d%0d_busy_cycles", D), bcnt, ST);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        bit all;
        all = 1'b0;
        for (int k = 0; k < 20000 && !all; k++) begin
            @(negedge clk);
            all = fin8 && g4[0].fin && g4[1].fin && g4[2].fin;
        end
        chk("all_finished", int'(all), 1);
        chk("w4d1_drain", g4[0].q.size(), 0);
        chk("w4d2_drain", g4[1].q.size(), 0);
        chk("w4d4_drain", g4[2].q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
